// File: rtl/egg_timer_pkg.sv
// egg_timer_pkg: state encodings, BCD digit width and seconds limit shared by the egg timer.
package egg_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DIGIT_W = 4;
    localparam int SEC_MAX = 59;

    function automatic logic [2*DIGIT_W-1:0] to_bcd(int v);
        return {DIGIT_W'(v / 10), DIGIT_W'(v % 10)};
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// bcd2_counter: two-digit BCD up/down counter wrapping between 00 and MAX.
// Priority is load, then dec, then inc; borrow flags a decrement out of 00.
module bcd2_counter
    import egg_timer_pkg::*;
#(
    parameter int MAX = 59,
    parameter logic [2*DIGIT_W-1:0] INIT = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inc,
    input  logic                   dec,
    input  logic                   load,
    input  logic [2*DIGIT_W-1:0]   load_val,
    output logic [2*DIGIT_W-1:0]   value,
    output logic                   borrow
);

    localparam logic [2*DIGIT_W-1:0] MAX_BCD = to_bcd(MAX);

    logic [DIGIT_W-1:0] tens, ones;
    logic [2*DIGIT_W-1:0] up, down;

    assign tens   = value[2*DIGIT_W-1:DIGIT_W];
    assign ones   = value[DIGIT_W-1:0];
    assign borrow = dec && value == '0;
    assign down   = borrow ? MAX_BCD
                  : ones == '0 ? {tens - 1'b1, DIGIT_W'(9)}
                  : {tens, ones - 1'b1};
    assign up     = value == MAX_BCD ? '0
                  : ones == DIGIT_W'(9) ? {tens + 1'b1, DIGIT_W'(0)}
                  : {tens, ones + 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            value <= INIT;
        else if (load)
            value <= load_val;
        else if (dec)
            value <= down;
        else if (inc)
            value <= up;
    end

endmodule

// File: rtl/egg_timer_ctrl.sv
// egg_timer_ctrl: egg timer sequencer (setpoint, BCD countdown, IDLE/RUN/PAUSE/DONE FSM).
// Define EGG_CTRL_ALARM_TIMEOUT_EN to auto-clear DONE after ALARM_SECS ticks.
module egg_timer_ctrl
    import egg_timer_pkg::*;
#(
    parameter int MAX_MIN     = 59,
    parameter int DEFAULT_MIN = 3,
    parameter int DEFAULT_SEC = 0,
    parameter int ALARM_SECS  = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_min_inc,
    input  logic       btn_sec_inc,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       alarm,
    output logic [1:0] state
);

    localparam logic [15:0] RESET_TIME = {to_bcd(DEFAULT_MIN), to_bcd(DEFAULT_SEC)};

    if (MAX_MIN > 99 || DEFAULT_SEC > SEC_MAX || ALARM_SECS < 1) begin : g_bad_param
        $error("egg_timer_ctrl: parameter out of range");
    end

    state_t      state_q, next;
    logic [15:0] setpoint;
    logic        start, zero, go, load, expire;
    logic        sec_inc, min_inc, sec_dec, sec_borrow, min_borrow;

    assign start   = btn_start && !btn_stop;
    assign zero    = min_bcd == 8'h00 && sec_bcd == 8'h00;
    assign go      = state_q == IDLE && start && !zero;
    assign sec_inc = state_q == IDLE && btn_sec_inc && !go;
    assign min_inc = state_q == IDLE && btn_min_inc && !go;
    // Any start/stop press in RUN swallows a coincident tick.
    assign sec_dec = state_q == RUN && tick && !btn_start && !btn_stop;
    assign state   = state_q;

`ifdef EGG_CTRL_ALARM_TIMEOUT_EN
    localparam int AW = $clog2(ALARM_SECS + 1);
    logic [AW-1:0] alarm_cnt;
    assign expire = state_q == DONE && tick && alarm_cnt == AW'(ALARM_SECS - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            alarm_cnt <= '0;
        else if (state_q != DONE)
            alarm_cnt <= '0;
        else if (tick)
            alarm_cnt <= alarm_cnt + 1'b1;
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        next = state_q;
        load = 1'b0;
        case (state_q)
            IDLE:  next = go ? RUN : IDLE;
            RUN: begin
                if (btn_stop)
                    next = PAUSE;
                else if (sec_dec && ((min_bcd == 8'h00 && sec_bcd == 8'h01) || min_borrow))
                    next = DONE;
            end
            PAUSE: begin
                load = btn_stop;
                next = btn_stop ? IDLE : btn_start ? RUN : PAUSE;
            end
            DONE: begin
                load = btn_start || btn_stop || expire;
                next = load ? IDLE : DONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            running  <= 1'b0;
            alarm    <= 1'b0;
            setpoint <= RESET_TIME;
        end else begin
            state_q <= next;
            running <= next == RUN;
            alarm   <= next == DONE;
            if (go)
                setpoint <= {min_bcd, sec_bcd};
        end
    end

    bcd2_counter #(.MAX(SEC_MAX), .INIT(RESET_TIME[7:0])) u_sec (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (sec_inc),
        .dec      (sec_dec),
        .load     (load),
        .load_val (setpoint[7:0]),
        .value    (sec_bcd),
        .borrow   (sec_borrow)
    );

    bcd2_counter #(.MAX(MAX_MIN), .INIT(RESET_TIME[15:8])) u_min (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (min_inc),
        .dec      (sec_borrow),
        .load     (load),
        .load_val (setpoint[15:8]),
        .value    (min_bcd),
        .borrow   (min_borrow)
    );

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// tb_egg_timer_ctrl: directed plus random stimulus against a total-seconds reference model.
// Honours EGG_CTRL_ALARM_TIMEOUT_EN (DUT built with ALARM_SECS = 3).
module tb_egg_timer_ctrl;

    localparam int MAX_MIN = 59;
    localparam int ALARM   = 3;
`ifdef EGG_CTRL_ALARM_TIMEOUT_EN
    localparam bit TIMEOUT = 1'b1;
`else
    localparam bit TIMEOUT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0, btn_start = 1'b0, btn_stop = 1'b0;
    logic       btn_min_inc = 1'b0, btn_sec_inc = 1'b0;
    logic [7:0] min_bcd, sec_bcd;
    logic       running, alarm;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;
    int mm, ss, st, sp_m, sp_s, ac;

    egg_timer_ctrl #(
        .MAX_MIN(MAX_MIN), .DEFAULT_MIN(3), .DEFAULT_SEC(0), .ALARM_SECS(ALARM)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .btn_start(btn_start), .btn_stop(btn_stop),
        .btn_min_inc(btn_min_inc), .btn_sec_inc(btn_sec_inc), .min_bcd(min_bcd),
        .sec_bcd(sec_bcd), .running(running), .alarm(alarm), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd(int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("min_bcd", 16'(min_bcd), 16'(bcd(mm)));
        check("sec_bcd", 16'(sec_bcd), 16'(bcd(ss)));
        check("state", 16'(state), 16'(st));
        check("running", 16'(running), 16'(st == 1));
        check("alarm", 16'(alarm), 16'(st == 3));
    endtask

    task automatic model_reset();
        mm = 3; ss = 0; sp_m = 3; sp_s = 0; st = 0; ac = 0;
    endtask

    task automatic reload();
        st = 0; mm = sp_m; ss = sp_s;
    endtask

    task automatic model_step(bit tk, bit bst, bit bs, bit bmi, bit bsi);
        int t;
        bit start;
        start = bst && !bs;
        case (st)
            0: if (start && (mm != 0 || ss != 0)) begin
                   sp_m = mm; sp_s = ss; st = 1;
               end else begin
                   if (bmi) mm = (mm + 1) % (MAX_MIN + 1);
                   if (bsi) ss = (ss + 1) % 60;
               end
            1: if (bs) st = 2;
               else if (tk && !bst) begin
                   t = mm * 60 + ss - 1;
                   mm = t / 60; ss = t % 60;
                   if (t == 0) begin st = 3; ac = 0; end
               end
            2: if (bs) reload(); else if (bst) st = 1;
            default: if (bs || bst) reload();
               else if (TIMEOUT && tk) begin
                   ac++;
                   if (ac == ALARM) reload();
               end
        endcase
    endtask

    task automatic cyc(bit tk, bit bst, bit bs, bit bmi, bit bsi);
        tick = tk; btn_start = bst; btn_stop = bs; btn_min_inc = bmi; btn_sec_inc = bsi;
        @(posedge clk);
        model_step(tk, bst, bs, bmi, bsi);
        #1;
        tick = 0; btn_start = 0; btn_stop = 0; btn_min_inc = 0; btn_sec_inc = 0;
        check_all();
    endtask

    task automatic set_time(int m, int s);
        for (int i = 0; i < 100 && mm != m; i++) cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 60 && ss != s; i++) cyc(0, 0, 0, 0, 1);
        check("set_time", 16'({min_bcd, sec_bcd}), 16'({bcd(m), bcd(s)}));
    endtask

    task automatic to_idle();
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        check("reset_time", 16'({min_bcd, sec_bcd}), 16'h0300);
        rst_n = 1'b1;

        repeat (5) cyc(0, 0, 0, 0, 1);
        check("after_sec_inc", 16'({min_bcd, sec_bcd}), 16'h0305);
        cyc(0, 1, 0, 0, 0);
        check("run_running", 16'(running), 16'd1);
        repeat (3) cyc(1, 0, 0, 0, 0);
        check("after_3_ticks", 16'({min_bcd, sec_bcd}), 16'h0302);
        cyc(1, 1, 0, 0, 0);
        check("start_drops_tick", 16'(sec_bcd), 16'h02);

        to_idle();
        set_time(0, 2);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("done_state", 16'(state), 16'd3);
        check("done_alarm", 16'(alarm), 16'd1);
        cyc(0, 0, 1, 0, 0);
        check("stop_reload", 16'({min_bcd, sec_bcd}), 16'h0002);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        repeat (20) cyc(1, 0, 0, 0, 0);
`ifdef EGG_CTRL_ALARM_TIMEOUT_EN
        check("timeout_idle", 16'(state), 16'd0);
`else
        check("done_persists", 16'(state), 16'd3);
        cyc(0, 1, 0, 0, 0);
`endif

        set_time(1, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("min_borrow", 16'({min_bcd, sec_bcd}), 16'h0059);
        repeat (49) cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("ones_borrow", 16'({min_bcd, sec_bcd}), 16'h0009);
        to_idle();

        set_time(2, 30);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        check("pause_state", 16'(state), 16'd2);
        repeat (3) cyc(1, 0, 0, 0, 0);
        check("pause_frozen", 16'({min_bcd, sec_bcd}), 16'h0230);
        cyc(0, 1, 1, 0, 0);
        check("stop_beats_start", 16'(state), 16'd0);

        set_time(59, 59);
        cyc(0, 0, 0, 1, 1);
        check("double_wrap", 16'({min_bcd, sec_bcd}), 16'h0000);
        cyc(0, 1, 0, 0, 0);
        check("zero_start_ignored", 16'(state), 16'd0);

        for (int i = 0; i < 600; i++)
            cyc(1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);

        to_idle();
        set_time(1, 5);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check("async_reset_time", 16'({min_bcd, sec_bcd}), 16'h0300);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
